// File: rtl/return_stack.sv
// Hardware return-address stack for the fetch stage.
// A call pushes pc_in + 1. The top entry is always visible on stk0, so the PC
// can load it in the same cycle that ret is asserted; the pop happens on that edge.
// Storage is circular: on overflow the oldest entry is overwritten and the
// newest DEPTH return addresses are kept.
module return_stack #(
    parameter int AW    = 12,
    parameter int DEPTH = 8,
    parameter int CW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          call,
    input  logic          ret,
    input  logic [AW-1:0] pc_in,
    input  logic          clr_err,
    output logic [AW-1:0] stk0,
    output logic [CW-1:0] depth,
    output logic          empty,
    output logic          full,
    output logic          overflow,
    output logic          underflow
);

    localparam int PW = $clog2(DEPTH);

    logic [AW-1:0] ram [DEPTH];
    logic [PW-1:0] wp;
    logic [PW-1:0] top_idx;
    logic [AW-1:0] push_val;
    logic          do_push;
    logic          do_tail;
    logic          push_full;
    logic          pop_empty;

    assign top_idx  = wp - PW'(1);
    assign push_val = pc_in + AW'(1);

    assign empty = (depth == '0);
    assign full  = (depth == CW'(DEPTH));
    assign stk0  = empty ? '0 : ram[top_idx];

    // A combined call+ret on a non-empty stack replaces the top in place.
    // On an empty stack it is treated as a plain push.
    assign do_tail   = call && ret && !empty;
    assign do_push   = call && !do_tail;
    assign push_full = call && !ret && full;
    assign pop_empty = ret && empty;

    // Storage write: new entry at wp, or in-place replacement of the top.
    always_ff @(posedge clk) begin
        if (do_tail) begin
            ram[top_idx] <= push_val;
        end else if (do_push) begin
            ram[wp] <= push_val;
        end
    end

    // Pointer and occupancy update.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wp    <= '0;
            depth <= '0;
        end else if (do_push) begin
            wp <= wp + PW'(1);
            if (!full) begin
                depth <= depth + CW'(1);
            end
        end else if (ret && !call && !empty) begin
            wp    <= top_idx;
            depth <= depth - CW'(1);
        end
    end

    // Sticky error flags; a new error on the clear edge wins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= push_full || (overflow && !clr_err);
            underflow <= pop_empty || (underflow && !clr_err);
        end
    end

endmodule

// File: tb/tb_return_stack.sv
// Bench for return_stack: a queue-based reference stack predicts the outputs
// after each edge; predictions go through a scoreboard queue and are compared
// after the edge, alongside directed constant checks.
module tb_return_stack;

    localparam int AW    = 12;
    localparam int DEPTH = 8;
    localparam int CW    = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          call;
    logic          ret;
    logic [AW-1:0] pc_in;
    logic          clr_err;
    logic [AW-1:0] stk0;
    logic [CW-1:0] depth;
    logic          empty;
    logic          full;
    logic          overflow;
    logic          underflow;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [AW-1:0] stk0;
        logic [CW-1:0] depth;
        logic          empty;
        logic          full;
        logic          ovf;
        logic          unf;
    } exp_t;

    exp_t          sb[$];
    logic [AW-1:0] m_stk[$];
    logic          m_ovf;
    logic          m_unf;

    return_stack #(.AW(AW), .DEPTH(DEPTH), .CW(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .call      (call),
        .ret       (ret),
        .pc_in     (pc_in),
        .clr_err   (clr_err),
        .stk0      (stk0),
        .depth     (depth),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: advance one edge and queue the predicted outputs.
    task automatic model_edge(input logic r_n, input logic c, input logic r,
                              input logic [AW-1:0] pc, input logic clr);
        logic [AW-1:0] pv;
        logic          set_o;
        logic          set_u;
        exp_t          e;
        pv    = pc + 12'd1;
        set_o = 1'b0;
        set_u = 1'b0;
        if (!r_n) begin
            m_stk.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            if (c && r) begin
                if (m_stk.size() > 0) begin
                    m_stk[m_stk.size()-1] = pv;
                end else begin
                    set_u = 1'b1;
                    m_stk.push_back(pv);
                end
            end else if (c) begin
                if (m_stk.size() == DEPTH) begin
                    void'(m_stk.pop_front());
                    set_o = 1'b1;
                end
                m_stk.push_back(pv);
            end else if (r) begin
                if (m_stk.size() > 0) void'(m_stk.pop_back());
                else set_u = 1'b1;
            end
            m_ovf = set_o | (m_ovf & ~clr);
            m_unf = set_u | (m_unf & ~clr);
        end
        e.stk0  = (m_stk.size() > 0) ? m_stk[m_stk.size()-1] : '0;
        e.depth = CW'(m_stk.size());
        e.empty = (m_stk.size() == 0);
        e.full  = (m_stk.size() == DEPTH);
        e.ovf   = m_ovf;
        e.unf   = m_unf;
        sb.push_back(e);
    endtask

    // Drive one edge, then pop the scoreboard and compare every output.
    task automatic step(input logic r_n, input logic c, input logic r,
                        input logic [AW-1:0] pc, input logic clr);
        exp_t e;
        @(negedge clk);
        rst_n   = r_n;
        call    = c;
        ret     = r;
        pc_in   = pc;
        clr_err = clr;
        model_edge(r_n, c, r, pc, clr);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("sb_stk0",      16'(stk0),      16'(e.stk0));
        check("sb_depth",     16'(depth),     16'(e.depth));
        check("sb_empty",     16'(empty),     16'(e.empty));
        check("sb_full",      16'(full),      16'(e.full));
        check("sb_overflow",  16'(overflow),  16'(e.ovf));
        check("sb_underflow", 16'(underflow), 16'(e.unf));
    endtask

    initial begin
        rst_n   = 1'b0;
        call    = 1'b0;
        ret     = 1'b0;
        pc_in   = '0;
        clr_err = 1'b0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;

        // Reset then idle
        step(0, 0, 0, 12'h000, 0);
        step(0, 0, 0, 12'h000, 0);
        step(1, 0, 0, 12'h000, 0);
        check("rst_stk0",  16'(stk0), 16'h0000);
        check("rst_depth", 16'(depth), 16'd0);
        check("rst_empty", 16'(empty), 16'd1);
        check("rst_full",  16'(full), 16'd0);
        check("rst_flags", 16'({overflow, underflow}), 16'd0);

        // Push/pop order
        step(1, 1, 0, 12'h010, 0);
        step(1, 1, 0, 12'h020, 0);
        check("push2_stk0",  16'(stk0), 16'h0021);
        check("push2_depth", 16'(depth), 16'd2);
        step(1, 0, 1, 12'h000, 0);
        check("pop1_stk0", 16'(stk0), 16'h0011);
        step(1, 0, 1, 12'h000, 0);
        check("pop2_stk0",  16'(stk0), 16'h0000);
        check("pop2_empty", 16'(empty), 16'd1);
        check("pop2_unf",   16'(underflow), 16'd0);

        // Overflow wrap
        for (int i = 0; i < 9; i++) step(1, 1, 0, AW'(12'h100 + i), 0);
        check("ovf_full",  16'(full), 16'd1);
        check("ovf_depth", 16'(depth), 16'd8);
        check("ovf_flag",  16'(overflow), 16'd1);
        check("ovf_stk0",  16'(stk0), 16'h0109);
        for (int i = 0; i < 7; i++) begin
            step(1, 0, 1, 12'h000, 0);
            check("wrap_pop_stk0", 16'(stk0), 16'(12'h108 - i));
        end
        step(1, 0, 1, 12'h000, 0);
        check("wrap_end_stk0",  16'(stk0), 16'h0000);
        check("wrap_end_empty", 16'(empty), 16'd1);

        // Underflow and clear
        step(1, 0, 1, 12'h000, 0);
        check("unf_flag",  16'(underflow), 16'd1);
        check("unf_depth", 16'(depth), 16'd0);
        step(1, 0, 0, 12'h000, 1);
        check("clr_unf", 16'(underflow), 16'd0);
        check("clr_ovf", 16'(overflow), 16'd0);
        step(1, 0, 1, 12'h000, 1);
        check("clr_set_wins", 16'(underflow), 16'd1);
        step(1, 0, 0, 12'h000, 1);

        // Simultaneous ops and arithmetic wrap
        step(1, 1, 0, 12'h050, 0);
        check("p50_stk0", 16'(stk0), 16'h0051);
        step(1, 1, 1, 12'hFFF, 0);
        check("tail_wrap_stk0",  16'(stk0), 16'h0000);
        check("tail_wrap_depth", 16'(depth), 16'd1);
        check("tail_wrap_empty", 16'(empty), 16'd0);
        step(1, 0, 1, 12'h000, 0);
        step(1, 1, 1, 12'h030, 0);
        check("tail_empty_depth", 16'(depth), 16'd1);
        check("tail_empty_stk0",  16'(stk0), 16'h0031);
        check("tail_empty_unf",   16'(underflow), 16'd1);
        step(1, 0, 0, 12'h000, 1);
        step(1, 0, 1, 12'h000, 0);

        // Reset mid-operation
        step(1, 1, 0, 12'h300, 0);
        step(1, 1, 0, 12'h301, 0);
        step(1, 1, 0, 12'h302, 0);
        check("pre_rst_depth", 16'(depth), 16'd3);
        step(0, 1, 0, 12'h303, 0);
        check("mid_rst_depth", 16'(depth), 16'd0);
        check("mid_rst_stk0",  16'(stk0), 16'h0000);
        step(1, 1, 0, 12'h200, 0);
        check("post_rst_stk0",  16'(stk0), 16'h0201);
        check("post_rst_depth", 16'(depth), 16'd1);
        step(1, 0, 0, 12'h000, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
